// File: rtl/ps2_pkg.sv
// Purpose: shared types, scan-code constants and the button lookup for the PS/2 receive path.
// Latency: none (package only).
// Backpressure: none (package only).
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Set-2 make codes for the game buttons, in button-index order
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [3:0] BTN_NONE = 4'd9;

  function automatic logic [3:0] scan_to_index(input logic [7:0] code);
    case (code)
      SC_A:    scan_to_index = 4'd0;
      SC_D:    scan_to_index = 4'd1;
      SC_E:    scan_to_index = 4'd2;
      SC_F:    scan_to_index = 4'd3;
      SC_G:    scan_to_index = 4'd4;
      SC_R:    scan_to_index = 4'd5;
      SC_S:    scan_to_index = 4'd6;
      SC_T:    scan_to_index = 4'd7;
      SC_W:    scan_to_index = 4'd8;
      default: scan_to_index = BTN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Purpose: synchronise raw ps2_clk/ps2_data into clk and flag ps2_clk falling edges.
// Latency: clk_fall asserts SYNC_STAGES+1 clk after ps2_clk falls; data_s is aligned with it.
// Backpressure: none; free-running, one-cycle clk_fall pulse per falling edge.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data raw async inputs;
//        clk_fall one-cycle falling-edge pulse; data_s ps2_data sampled alongside clk_fall.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;

  // Reset to the idle-high line level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      clk_fall  <= 1'b0;
      data_s    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      clk_fall  <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data_s    <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// Purpose: receive PS/2 keyboard frames and map set-2 scan codes to game button indices.
// Latency: key_valid/frame_error pulse 1 clk after the stop-bit edge is seen in the clk domain.
// Backpressure: none; outputs are pulses and held values, the keyboard cannot be stalled.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data raw keyboard lines;
//        key_valid pulse with key_index/scan_code/key_released; frame_error pulse.
// Option: define PS2_BREAK_TRACK_EN to fold F0 break prefixes into key_released.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [3:0] key_index,
  output logic [7:0] scan_code,
  output logic       key_released,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  rx_state_t     state, state_nxt;
  logic          clk_fall;
  logic          din;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok;
  logic          frame_bad;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_fall (clk_fall),
    .data_s   (din)
  );

  // An edge in the expiry cycle wins: the frame is still alive
  assign tmo_hit = (state != IDLE) && !clk_fall && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clk_fall && !din) state_nxt = DATA;
      DATA:    if (tmo_hit) state_nxt = IDLE;
               else if (clk_fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:  if (tmo_hit) state_nxt = IDLE;
               else if (clk_fall) state_nxt = STOP;
      STOP:    if (tmo_hit || clk_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Odd parity over data+parity, stop bit must be high
  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = tmo_hit;
    if (state == STOP && clk_fall) begin
      frame_ok  = din && (^{shift, parity_bit});
      frame_bad = !frame_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (state == IDLE || clk_fall) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)   tmo_cnt <= tmo_cnt + TW'(1);

      if (clk_fall) begin
        case (state)
          IDLE:   bit_cnt <= 3'd0;
          DATA: begin
            shift[bit_cnt] <= din;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          PARITY: parity_bit <= din;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_TRACK_EN
  logic break_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid    <= 1'b0;
      frame_error  <= 1'b0;
      key_index    <= BTN_NONE;
      scan_code    <= 8'd0;
      key_released <= 1'b0;
      break_flag   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      frame_error <= frame_bad;
      if (frame_bad) break_flag <= 1'b0;
      // E0 is swallowed without touching the break flag so E0 F0 xx still
      // reports a release of xx
      if (frame_ok && shift != SC_EXT) begin
        if (shift == SC_BREAK) begin
          break_flag <= 1'b1;
        end else begin
          key_valid    <= 1'b1;
          key_index    <= scan_to_index(shift);
          scan_code    <= shift;
          key_released <= break_flag;
          break_flag   <= 1'b0;
        end
      end
    end
  end
`else
  assign key_released = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid   <= 1'b0;
      frame_error <= 1'b0;
      key_index   <= BTN_NONE;
      scan_code   <= 8'd0;
    end else begin
      key_valid   <= 1'b0;
      frame_error <= frame_bad;
      if (frame_ok && shift != SC_EXT) begin
        key_valid <= 1'b1;
        key_index <= scan_to_index(shift);
        scan_code <= shift;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Purpose: self-checking bench for ps2_keyboard_receiver using an expected-event queue.
// Latency: frame-end events are checked to land exactly 4 clk after the stop-bit fall is driven.
// Backpressure: none; every key_valid/frame_error pulse must match the queue head.
module tb_ps2_keyboard_receiver;

  localparam int TMO = 500;
  localparam int HP  = 40;   // half ps2_clk period in clk cycles

  typedef struct {
    bit         err;
    logic [3:0] idx;
    logic [7:0] code;
    bit         rel;
    bit         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [3:0] key_index;
  logic [7:0] scan_code;
  logic       key_released;
  logic       frame_error;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;
  exp_t expq[$];

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_valid    (key_valid),
    .key_index    (key_index),
    .scan_code    (scan_code),
    .key_released (key_released),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic push(input bit err, input logic [3:0] idx, input logic [7:0] code,
                      input bit rel, input bit lat);
    exp_t e;
    e.err = err; e.idx = idx; e.code = code; e.rel = rel; e.lat = lat;
    expq.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; bad_par inverts the odd-parity bit
  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_vld", key_valid, 0);
    check("rst_err", frame_error, 0);
    check("rst_idx", key_index, 9);
    check("rst_rel", key_released, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (key_valid || frame_error)) begin
      if (expq.size() == 0) begin
        check("spurious", {key_valid, frame_error}, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("err", frame_error, e.err);
        check("vld", key_valid, !e.err);
        if (!e.err) begin
          check("idx", key_index, e.idx);
          check("code", scan_code, e.code);
          check("rel", key_released, e.rel);
        end
        if (e.lat) check("lat", cyc, last_fall + 4);
      end
    end
  end

  initial begin
    // 1: reset values
    repeat (2) @(negedge clk);
    do_reset();

    // Falling edge with data high while idle is ignored
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);

    // 2: good 0x1C
    push(0, 4'd0, 8'h1C, 0, 1);
    send(8'h1C, 0, 11);

    // 3: 0x23 with wrong parity, previous key held
    push(1, 4'd0, 8'h00, 0, 1);
    send(8'h23, 1, 11);
    repeat (5) @(negedge clk);
    check("hold_idx", key_index, 0);
    check("hold_code", scan_code, 8'h1C);

    // 4: timeout after start + 4 data bits, then 0x1D
    push(1, 4'd0, 8'h00, 0, 0);
    send(8'h1D, 0, 5);
    repeat (TMO + 50) @(negedge clk);
    push(0, 4'd8, 8'h1D, 0, 1);
    send(8'h1D, 0, 11);

    // Extended prefix is swallowed, following byte decodes normally
    send(8'hE0, 0, 11);
    push(0, 4'd0, 8'h1C, 0, 1);
    send(8'h1C, 0, 11);

    // 5: break prefix then 0x1B
`ifdef PS2_BREAK_TRACK_EN
    send(8'hF0, 0, 11);
    push(0, 4'd6, 8'h1B, 1, 1);
    send(8'h1B, 0, 11);
`else
    push(0, 4'd9, 8'hF0, 0, 1);
    send(8'hF0, 0, 11);
    push(0, 4'd6, 8'h1B, 0, 1);
    send(8'h1B, 0, 11);
`endif

    // 6: reset mid-frame, then unmapped 0x15
    send(8'h2C, 0, 6);
    do_reset();
    push(0, 4'd9, 8'h15, 0, 1);
    send(8'h15, 0, 11);

    repeat (TMO + 50) @(negedge clk);
    check("drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
